// File: rtl/core2ahb_master.sv
// Core request/response to AHB-Lite single-transfer master with address and data pipeline slots.
// Define CORE2AHB_STAT_EN to add the stat_xfer_o / stat_wait_o transfer and wait-cycle counters.
module core2ahb_master #(
   parameter int unsigned BUS_W = 32
) (
   input  logic             HCLK,
   input  logic             HRST,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [BUS_W-1:0] req_addr_i,
   input  logic [BUS_W-1:0] req_wdata_i,
   input  logic             req_write_i,
   input  logic [2:0]       req_size_i,
   output logic             rsp_valid_o,
   output logic [BUS_W-1:0] rsp_rdata_o,
   output logic             rsp_err_o,
   output logic [BUS_W-1:0] HADDR_o,
   output logic             HWRITE_o,
   output logic [2:0]       HSIZE_o,
   output logic [1:0]       HTRANS_o,
   output logic [2:0]       HBURST_o,
   output logic [3:0]       HPROT_o,
   output logic [BUS_W-1:0] HWDATA_o,
   input  logic [BUS_W-1:0] HRDATA_i,
   input  logic             HREADY_i,
   input  logic             HRESP_i
`ifdef CORE2AHB_STAT_EN
   ,
   output logic [31:0]      stat_xfer_o,
   output logic [31:0]      stat_wait_o
`endif
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_MAX     = 3'd2;

   // A slot: address phase; a_err marks requests that must answer ERROR without a bus transfer
   logic             a_valid_q, a_valid_d;
   logic             a_err_q, a_err_d;
   logic             a_write_q, a_write_d;
   logic [2:0]       a_size_q, a_size_d;
   logic [BUS_W-1:0] a_addr_q, a_addr_d;
   logic [BUS_W-1:0] a_wdata_q, a_wdata_d;
   // D slot: data phase
   logic             d_valid_q, d_valid_d;
   logic             d_err_q, d_err_d;
   logic             d_write_q, d_write_d;
   logic [1:0]       htrans_q, htrans_d;
   logic [BUS_W-1:0] hwdata_q, hwdata_d;
   logic             err_cancel_q, err_cancel_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q, rsp_err_d;
   logic [BUS_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic err_first_c, a_adv_c, d_done_c, accept_c;

   assign err_first_c = d_valid_q && !d_err_q && !HREADY_i && HRESP_i;
   assign a_adv_c     = a_valid_q && HREADY_i;
   assign d_done_c    = d_valid_q && HREADY_i;
   assign req_ready_o = (!a_valid_q || HREADY_i) && !(err_cancel_q || err_first_c);
   assign accept_c    = req_valid_i && req_ready_o;

   always_comb begin
      a_valid_d    = a_valid_q;
      a_err_d      = a_err_q;
      a_write_d    = a_write_q;
      a_size_d     = a_size_q;
      a_addr_d     = a_addr_q;
      a_wdata_d    = a_wdata_q;
      d_valid_d    = d_valid_q;
      d_err_d      = d_err_q;
      d_write_d    = d_write_q;
      hwdata_d     = hwdata_q;
      err_cancel_d = err_cancel_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = rsp_err_q;
      rsp_rdata_d  = rsp_rdata_q;

      if (accept_c) begin
         a_valid_d = 1'b1;
         a_err_d   = req_size_i > HSIZE_MAX;
         a_write_d = req_write_i;
         a_size_d  = req_size_i;
         a_addr_d  = req_addr_i;
         a_wdata_d = req_wdata_i;
      end else if (a_adv_c) begin
         a_valid_d = 1'b0;
      end

      // First ERROR cycle: withdraw the pending address phase, it answers ERROR later
      if (err_first_c && a_valid_q) begin
         a_err_d = 1'b1;
      end

      if (a_adv_c) begin
         d_valid_d = 1'b1;
         d_err_d   = a_err_q;
         d_write_d = a_write_q;
         hwdata_d  = a_wdata_q;
      end else if (d_done_c) begin
         d_valid_d = 1'b0;
      end

      if (err_first_c) begin
         err_cancel_d = 1'b1;
      end else if (d_done_c && !(a_valid_q && a_err_q)) begin
         err_cancel_d = 1'b0;
      end

      if (d_done_c) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = d_err_q || HRESP_i;
         rsp_rdata_d = (d_write_q || d_err_q) ? '0 : HRDATA_i;
      end

      htrans_d = (a_valid_d && !a_err_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
   end

   always_ff @(posedge HCLK) begin
      if (HRST) begin
         a_valid_q    <= 1'b0;
         a_err_q      <= 1'b0;
         a_write_q    <= 1'b0;
         a_size_q     <= '0;
         a_addr_q     <= '0;
         a_wdata_q    <= '0;
         d_valid_q    <= 1'b0;
         d_err_q      <= 1'b0;
         d_write_q    <= 1'b0;
         htrans_q     <= HTRANS_IDLE;
         hwdata_q     <= '0;
         err_cancel_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
      end else begin
         a_valid_q    <= a_valid_d;
         a_err_q      <= a_err_d;
         a_write_q    <= a_write_d;
         a_size_q     <= a_size_d;
         a_addr_q     <= a_addr_d;
         a_wdata_q    <= a_wdata_d;
         d_valid_q    <= d_valid_d;
         d_err_q      <= d_err_d;
         d_write_q    <= d_write_d;
         htrans_q     <= htrans_d;
         hwdata_q     <= hwdata_d;
         err_cancel_q <= err_cancel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   assign HADDR_o     = a_addr_q;
   assign HWRITE_o    = a_write_q;
   assign HSIZE_o     = a_size_q;
   assign HTRANS_o    = htrans_q;
   assign HWDATA_o    = hwdata_q;
   assign HBURST_o    = 3'b000;
   assign HPROT_o     = 4'b0011;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

`ifdef CORE2AHB_STAT_EN
   logic [31:0] stat_xfer_q, stat_xfer_d;
   logic [31:0] stat_wait_q, stat_wait_d;

   // Free-running wrap-around counters of completed data phases and data-phase wait cycles
   always_comb begin
      stat_xfer_d = stat_xfer_q;
      stat_wait_d = stat_wait_q;
      if (d_done_c) begin
         stat_xfer_d = stat_xfer_q + 32'd1;
      end
      if (d_valid_q && !HREADY_i) begin
         stat_wait_d = stat_wait_q + 32'd1;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRST) begin
         stat_xfer_q <= '0;
         stat_wait_q <= '0;
      end else begin
         stat_xfer_q <= stat_xfer_d;
         stat_wait_q <= stat_wait_d;
      end
   end

   assign stat_xfer_o = stat_xfer_q;
   assign stat_wait_o = stat_wait_q;
`endif

endmodule
